// File: rtl/cb_merge.sv
// Two-input round-robin merge stage with a DEPTH-entry FIFO and 4-phase Send/Ack handshakes.
// Optional macro CB_MERGE_TAG_EN adds a per-entry source bit presented on Src_out.
module cb_merge #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          CP,
   input  logic          MR,
   input  logic          Send_in_a,
   input  logic [W-1:0]  Data_in_a,
   output logic          Ack_out_a,
   input  logic          Send_in_b,
   input  logic [W-1:0]  Data_in_b,
   output logic          Ack_out_b,
   output logic          Send_out,
   output logic [W-1:0]  Data_out,
   input  logic          Ack_in,
   output logic [CW-1:0] Count
`ifdef CB_MERGE_TAG_EN
   ,
   output logic          Src_out
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CB_MERGE_TAG_EN
   localparam int unsigned EW = W + 1;
`else
   localparam int unsigned EW = W;
`endif
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   typedef enum logic {IIdle, IAck} in_st_t;
   typedef enum logic [1:0] {OIdle, OSend, ORtz} out_st_t;

   in_st_t        r_st_a, r_st_b;
   out_st_t       r_st_o;
   logic          r_prefer_b;
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic [EW-1:0] r_mem [DEPTH];

   logic          w_req_a, w_req_b, w_full;
   logic          w_gnt_a, w_gnt_b, w_push, w_pop;
   logic [EW-1:0] w_wdata, w_head;

   // Fullness is judged on the pre-edge count, so a same-edge pop never frees a write slot.
   assign w_full  = (Count == FULL_CNT);
   assign w_req_a = Send_in_a && (r_st_a == IIdle);
   assign w_req_b = Send_in_b && (r_st_b == IIdle);
   assign w_gnt_a = !w_full && w_req_a && (!w_req_b || !r_prefer_b);
   assign w_gnt_b = !w_full && w_req_b && (!w_req_a || r_prefer_b);
   assign w_push  = w_gnt_a || w_gnt_b;
   assign w_pop   = (r_st_o == OSend) && Ack_in;
   assign w_head  = r_mem[r_rd_ptr];

`ifdef CB_MERGE_TAG_EN
   assign w_wdata = w_gnt_b ? {1'b1, Data_in_b} : {1'b0, Data_in_a};
`else
   assign w_wdata = w_gnt_b ? Data_in_b : Data_in_a;
`endif

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         r_st_a     <= IIdle;
         r_st_b     <= IIdle;
         Ack_out_a  <= 1'b0;
         Ack_out_b  <= 1'b0;
         r_prefer_b <= 1'b0;
      end else begin
         case (r_st_a)
            IIdle: if (w_gnt_a) begin
               Ack_out_a <= 1'b1;
               r_st_a    <= IAck;
            end
            IAck: if (!Send_in_a) begin
               Ack_out_a <= 1'b0;
               r_st_a    <= IIdle;
            end
            default: r_st_a <= IIdle;
         endcase

         case (r_st_b)
            IIdle: if (w_gnt_b) begin
               Ack_out_b <= 1'b1;
               r_st_b    <= IAck;
            end
            IAck: if (!Send_in_b) begin
               Ack_out_b <= 1'b0;
               r_st_b    <= IIdle;
            end
            default: r_st_b <= IIdle;
         endcase

         if (w_gnt_a) begin
            r_prefer_b <= 1'b1;
         end else if (w_gnt_b) begin
            r_prefer_b <= 1'b0;
         end
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         r_st_o   <= OIdle;
         Send_out <= 1'b0;
         Data_out <= '0;
`ifdef CB_MERGE_TAG_EN
         Src_out  <= 1'b0;
`endif
      end else begin
         case (r_st_o)
            // A stray Ack_in held high blocks the launch until it returns low.
            OIdle: if ((Count != '0) && !Ack_in) begin
               Send_out <= 1'b1;
               Data_out <= w_head[W-1:0];
`ifdef CB_MERGE_TAG_EN
               Src_out  <= w_head[W];
`endif
               r_st_o   <= OSend;
            end
            OSend: if (Ack_in) begin
               Send_out <= 1'b0;
               r_st_o   <= ORtz;
            end
            ORtz: if (!Ack_in) begin
               r_st_o <= OIdle;
            end
            default: r_st_o <= OIdle;
         endcase
      end
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         Count    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   Count <= Count + CW'(1);
            2'b01:   Count <= Count - CW'(1);
            default: Count <= Count;
         endcase
      end
   end

   always_ff @(posedge CP) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wdata;
      end
   end

endmodule

// File: tb/tb_cb_merge.sv
// Self-checking bench for cb_merge: queue-based reference model compared every cycle,
// directed literal checks plus randomized producers/consumer.
module tb_cb_merge;

   localparam int unsigned W     = 8;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          mr  = 1'b1;
   logic          send_a = 1'b0, send_b = 1'b0, ack_in = 1'b0;
   logic [W-1:0]  data_a = '0, data_b = '0;
   logic          ack_a, ack_b, send_out;
   logic [W-1:0]  data_out;
   logic [CW-1:0] count;
`ifdef CB_MERGE_TAG_EN
   logic          src_out;
`endif

   int checks = 0;
   int errors = 0;

   cb_merge #(.W(W), .DEPTH(DEPTH)) dut (
      .CP        (clk),
      .MR        (mr),
      .Send_in_a (send_a),
      .Data_in_a (data_a),
      .Ack_out_a (ack_a),
      .Send_in_b (send_b),
      .Data_in_b (data_b),
      .Ack_out_b (ack_b),
      .Send_out  (send_out),
      .Data_out  (data_out),
      .Ack_in    (ack_in),
      .Count     (count)
`ifdef CB_MERGE_TAG_EN
      ,
      .Src_out   (src_out)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of {src,data} in grant order plus handshake-level flags.
   logic [W:0]   mq[$];
   bit           m_ack_a = 0, m_ack_b = 0, m_send = 0, m_rtz = 0, m_prefer_b = 0, m_src = 0;
   logic [W-1:0] m_data = '0;
   bit           ra, rb, full, ga, gb;

   initial begin
      forever begin
         @(posedge clk or posedge mr);
         if (mr) begin
            mq.delete();
            m_ack_a = 0; m_ack_b = 0; m_send = 0; m_rtz = 0; m_prefer_b = 0;
            m_src = 0; m_data = '0;
         end else begin
            ra   = send_a && !m_ack_a;
            rb   = send_b && !m_ack_b;
            full = (mq.size() >= DEPTH);
            ga   = !full && ra && (!rb || !m_prefer_b);
            gb   = !full && rb && !ga;
            if (!m_send && !m_rtz && mq.size() > 0 && !ack_in) begin
               m_data = mq[0][W-1:0];
               m_src  = mq[0][W];
               m_send = 1;
            end else if (m_send && ack_in) begin
               m_send = 0;
               m_rtz  = 1;
               void'(mq.pop_front());
            end else if (m_rtz && !ack_in) begin
               m_rtz = 0;
            end
            if (ga) begin
               mq.push_back({1'b0, data_a});
               m_ack_a    = 1;
               m_prefer_b = 1;
            end else if (!send_a) begin
               m_ack_a = 0;
            end
            if (gb) begin
               mq.push_back({1'b1, data_b});
               m_ack_b    = 1;
               m_prefer_b = 0;
            end else if (!send_b) begin
               m_ack_b = 0;
            end
         end
      end
   end

   logic [W-1:0] seen[$];
   logic         prev_send = 1'b0;
   int           recv = 0;
   int           max_count = 0;

   initial begin
      forever begin
         @(negedge clk);
         chk("ack_a", 32'(ack_a), 32'(m_ack_a));
         chk("ack_b", 32'(ack_b), 32'(m_ack_b));
         chk("send_out", 32'(send_out), 32'(m_send));
         chk("data_out", 32'(data_out), 32'(m_data));
         chk("count", 32'(count), 32'(mq.size()));
`ifdef CB_MERGE_TAG_EN
         chk("src_out", 32'(src_out), 32'(m_src));
`endif
         if (int'(count) > max_count) max_count = int'(count);
         if (send_out && !prev_send) begin
            seen.push_back(data_out);
            recv++;
         end
         prev_send = send_out;
      end
   end

   // Consumer: acks Send_out after cons_dly cycles, optionally injects stray idle acks.
   bit cons_en = 0, cons_rand = 0, cons_viol = 0;
   int cons_dly = 0, dly_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (cons_en) begin
            if (!ack_in && send_out) begin
               if (dly_cnt >= cons_dly) begin
                  ack_in  = 1'b1;
                  dly_cnt = 0;
               end else begin
                  dly_cnt++;
               end
            end else if (ack_in && !send_out) begin
               ack_in = 1'b0;
               if (cons_rand) cons_dly = $urandom_range(0, 5);
            end else if (!ack_in && cons_viol && $urandom_range(0, 15) == 0) begin
               ack_in = 1'b1;
            end
         end
      end
   end

   int sent = 0;

   task automatic send_pkt(input bit side, input logic [W-1:0] d);
      int n;
      @(negedge clk);
      if (side) begin data_b = d; send_b = 1'b1; end
      else      begin data_a = d; send_a = 1'b1; end
      n = 0;
      while (!(side ? ack_b : ack_a) && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin
         checks++; errors++;
         $display("FAIL ack_rise_timeout side %0d: got 0 expected 1", side);
      end
      sent++;
      // Data changes after capture must be ignored.
      if ($urandom_range(0, 3) == 0) begin
         if (side) data_b = W'($urandom); else data_a = W'($urandom);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (side) send_b = 1'b0; else send_a = 1'b0;
      n = 0;
      while ((side ? ack_b : ack_a) && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) begin
         checks++; errors++;
         $display("FAIL ack_fall_timeout side %0d: got 1 expected 0", side);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 mr = 1'b1;
      @(negedge clk);
      mr = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((count != '0 || send_out || ack_in) && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got count %0d expected 0", count);
      end
      @(negedge clk);
   endtask

   int sent0, recv0;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ack_a", 32'(ack_a), 0);
      chk("rst_send_out", 32'(send_out), 0);
      chk("rst_count", 32'(count), 0);
      mr = 1'b0;

      // Single path latency
      @(negedge clk); data_a = 8'h5A; send_a = 1'b1;
      @(negedge clk);
      chk("sp_ack_a", 32'(ack_a), 1);
      chk("sp_send_early", 32'(send_out), 0);
      chk("sp_count1", 32'(count), 1);
      @(negedge clk);
      chk("sp_send", 32'(send_out), 1);
      chk("sp_data", 32'(data_out), 32'h5A);
      send_a = 1'b0; ack_in = 1'b1;
      @(negedge clk);
      chk("sp_send_low", 32'(send_out), 0);
      chk("sp_count0", 32'(count), 0);
      ack_in = 1'b0;
      @(negedge clk);

      // Contention: A wins first after reset
      do_reset();
      seen.delete();
      cons_en = 1; cons_dly = 0;
      data_a = 8'h11; data_b = 8'h22; send_a = 1'b1; send_b = 1'b1;
      @(negedge clk);
      chk("ct_ack_a", 32'(ack_a), 1);
      chk("ct_ack_b_wait", 32'(ack_b), 0);
      @(negedge clk);
      chk("ct_ack_b", 32'(ack_b), 1);
      send_a = 1'b0;
      @(negedge clk);
      fork
         send_pkt(1'b0, 8'h33);
         begin send_b = 1'b0; end
      join
      wait_drain();
      chk("ct_n", 32'(seen.size()), 3);
      if (seen.size() >= 3) begin
         chk("ct_0", 32'(seen[0]), 32'h11);
         chk("ct_1", 32'(seen[1]), 32'h22);
         chk("ct_2", 32'(seen[2]), 32'h33);
      end

      // Full FIFO blocks a third request until after the first pop
      do_reset();
      cons_en = 0; ack_in = 1'b0;
      send_pkt(1'b0, 8'hA1);
      send_pkt(1'b1, 8'hB2);
      chk("fu_count2", 32'(count), 2);
      data_a = 8'hC3; send_a = 1'b1;
      repeat (3) @(negedge clk);
      chk("fu_blocked", 32'(ack_a), 0);
      chk("fu_count_hold", 32'(count), 2);
      ack_in = 1'b1;
      @(negedge clk);
      chk("fu_pop_count", 32'(count), 1);
      chk("fu_no_same_edge", 32'(ack_a), 0);
      ack_in = 1'b0;
      @(negedge clk);
      chk("fu_granted", 32'(ack_a), 1);
      chk("fu_count_refill", 32'(count), 2);
      send_a = 1'b0;
      cons_en = 1;
      wait_drain();

      // Asynchronous reset mid-transfer
      cons_en = 0;
      @(negedge clk); data_a = 8'h77; send_a = 1'b1;
      @(negedge clk); chk("mr_pre_ack", 32'(ack_a), 1);
      @(negedge clk); chk("mr_pre_send", 32'(send_out), 1);
      #2 mr = 1'b1;
      #1;
      chk("mr_ack_a", 32'(ack_a), 0);
      chk("mr_send_out", 32'(send_out), 0);
      chk("mr_data_out", 32'(data_out), 0);
      chk("mr_count", 32'(count), 0);
      @(negedge clk); mr = 1'b0;
      @(negedge clk);
      chk("mr_reack", 32'(ack_a), 1);
      chk("mr_count1", 32'(count), 1);
      send_a = 1'b0;
      cons_en = 1;
      wait_drain();

      // Back-pressure: consumer delays 5 cycles, 6 alternating packets
      do_reset();
      seen.delete(); max_count = 0;
      cons_dly = 5;
      fork
         begin for (int i = 0; i < 3; i++) send_pkt(1'b0, W'(8'hA0 + i)); end
         begin for (int j = 0; j < 3; j++) send_pkt(1'b1, W'(8'hB0 + j)); end
      join
      wait_drain();
      chk("bp_n", 32'(seen.size()), 6);
      chk("bp_max_count", 32'(max_count <= DEPTH), 1);

`ifdef CB_MERGE_TAG_EN
      do_reset();
      cons_dly = 0;
      send_pkt(1'b0, 8'h01);
      send_pkt(1'b1, 8'h02);
      wait_drain();
`endif

      // Randomized traffic
      cons_rand = 1; cons_viol = 1;
      sent0 = sent; recv0 = recv;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               send_pkt(1'b0, W'($urandom));
            end
         end
         begin
            for (int j = 0; j < 40; j++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               send_pkt(1'b1, W'($urandom));
            end
         end
      join
      cons_viol = 0;
      wait_drain();
      chk("rnd_sent", 32'(sent - sent0), 80);
      chk("rnd_delivered", 32'(recv - recv0), 32'(sent - sent0));
      chk("rnd_max_count", 32'(max_count <= DEPTH), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
